dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Parametrised data-memory block for the RISC-V core, replacing the bare RAM hookup between the core data port and a single-cycle RAM. It holds an internal word-organised memory and performs RV32I byte, half and word loads and stores, little-endian. It has a REQ/READY handshake, a configurable read latency, sign/zero extension and misalignment/illegal-op detection. It sits between the core data port (DIR_DMEM, DATA_WRITE_DMEM, DATA_READ_DMEM, READ, WRITE) and the memory array.

Parameters:
DATA_W, 32, data word width; fixed at 32 for RV32I, any other value is a configuration error.
ADDR_W, 10, word-address width; depth = 2**ADDR_W words; byte address width = ADDR_W+2.
RD_LAT, 1, read latency in cycles from request acceptance to READY, legal range 1..4.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RESET_N  in  1  asynchronous, active-low reset.
REQ  in  1  access request; the core holds REQ, WE, FUNCT3, ADDR and WDATA stable until READY.
WE  in  1  1 = store, 0 = load.
FUNCT3  in  3  RV32I funct3 of the load/store instruction.
ADDR  in  ADDR_W+2  byte address.
WDATA  in  DATA_W  store data, taken from the low bits for SB/SH.
RDATA  out  DATA_W  load result, already extended; valid only while READY=1.
READY  out  1  one-cycle completion pulse.
ERR  out  1  valid with READY; 1 = misaligned or illegal FUNCT3, and the access was not performed.
BUSY  out  1  high from the acceptance edge until the cycle after READY.

Behaviour:
- Reset (RESET_N=0, asynchronous): state goes to IDLE; READY=0, ERR=0, BUSY=0, RDATA=0, latency counter=0. The memory array is not cleared and its contents are undefined after power-up.
- States: IDLE, WAIT, RESP.
- IDLE: when REQ=1, the request is accepted at the edge and BUSY goes to 1.
  - Error check first. Legal load FUNCT3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store FUNCT3: 000 SB, 001 SH, 010 SW. Any other code is illegal.
  - Misaligned: half access with ADDR[0]=1, or word access with ADDR[1:0]!=0.
  - On error: go to RESP with ERR=1 and RDATA=0. No memory read or write occurs.
  - Legal store: the write happens at the acceptance edge, using byte lane select from ADDR[1:0] (SB: 1 lane, SH: lanes {0,1} or {2,3}, SW: all 4). Next state is RESP.
  - Legal load with RD_LAT=1: go to RESP. With RD_LAT>1: go to WAIT with counter=RD_LAT-1.
- WAIT: counter decrements each cycle; when it reaches 1, next state is RESP.
- RESP: READY=1 for exactly one cycle.
  - RDATA is the extracted lane: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW returns the full word.
  - REQ is ignored in RESP. Next state is IDLE; BUSY drops one cycle after READY.
  - A REQ held high in IDLE after RESP is treated as a new request.
- Latency, measured from the acceptance edge to the READY cycle:
  - stores and errors: 1 cycle;
  - loads: RD_LAT cycles.
  - Minimum period between back-to-back accesses: latency + 1 cycle.
- Outside RESP, RDATA holds its last value and ERR=0.
- Request inputs are captured at acceptance; later changes before READY do not affect the result.
- Reset asserted mid-operation: the access is aborted and no READY is produced. A store already committed at the acceptance edge persists; a pending load is discarded.
- Address wrap: none needed; ADDR covers exactly the 2**ADDR_W words.

Test Plan:
- SW 0x8765_4321 @0x010, then LW @0x010 with RD_LAT=1 -> READY 1 cycle after each acceptance, RDATA=0x87654321, ERR=0.
- SB 0xAB @0x013, then LB @0x013 -> RDATA=0xFFFFFFAB; LBU @0x013 -> 0x000000AB; LW @0x010 -> 0xAB654321.
- SH 0x8001 @0x022, then LH @0x022 -> 0xFFFF8001; LHU -> 0x00008001; LH @0x021 -> READY with ERR=1, RDATA=0, memory unchanged.
- RD_LAT=3: LW accepted at edge t0 -> READY exactly at cycle t0+3, BUSY high t0..t0+3; REQ toggled during WAIT has no effect.
- Store with FUNCT3=011 @0x000 -> ERR=1 after 1 cycle; a following LW @0x000 returns the previous contents.
- RESET_N pulsed low during WAIT of a load -> READY, BUSY, ERR and RDATA go to 0 immediately; after release, state is IDLE and the next LW completes normally.

Source files
------------

// File: rtl/dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_ctrl : RV32I byte/half/word data memory with REQ/READY handshake     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module dmem_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                REQ,
   input  logic                WE,
   input  logic [2:0]          FUNCT3,
   input  logic [ADDR_W+1:0]   ADDR,
   input  logic [DATA_W-1:0]   WDATA,
   output logic [DATA_W-1:0]   RDATA,
   output logic                READY,
   output logic                ERR,
   output logic                BUSY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] c_wait_init = 3'(RD_LAT - 1);

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [1:0]          lane_q, lane_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [DATA_W-1:0]   mem [2**ADDR_W];

   logic [ADDR_W-1:0]   w_widx;
   logic [DATA_W-1:0]   w_rd_word;
   logic                w_legal;
   logic                w_misal;
   logic                w_bad;
   logic                w_store;
   logic [3:0]          w_be;
   logic [DATA_W-1:0]   w_wlanes;

   function automatic logic [DATA_W-1:0] f_extract(input logic [DATA_W-1:0] w,
                                                   input logic [2:0]        f3,
                                                   input logic [1:0]        lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*lane +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  f_extract = {{(DATA_W-8){b[7]}}, b};
         3'b001:  f_extract = {{(DATA_W-16){h[15]}}, h};
         3'b010:  f_extract = w;
         3'b100:  f_extract = {{(DATA_W-8){1'b0}}, b};
         3'b101:  f_extract = {{(DATA_W-16){1'b0}}, h};
         default: f_extract = '0;
      endcase
   endfunction

   assign w_widx    = ADDR[ADDR_W+1:2];
   assign w_rd_word = mem[w_widx];

   always_comb begin
      w_legal = 1'b0;
      w_misal = 1'b0;
      if (WE) w_legal = (FUNCT3 == 3'b000) || (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010);
      else    w_legal = (FUNCT3 == 3'b000) || (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) ||
                        (FUNCT3 == 3'b100) || (FUNCT3 == 3'b101);
      if (FUNCT3[1:0] == 2'b01) w_misal = ADDR[0];
      if (FUNCT3[1:0] == 2'b10) w_misal = (ADDR[1:0] != 2'b00);
   end

   assign w_bad   = !w_legal || w_misal;
   assign w_store = (state_q == IDLE) && REQ && WE && !w_bad;

   // Stores replicate the low data bits across lanes; byte enables pick the target.
   always_comb begin
      w_be     = 4'b0000;
      w_wlanes = WDATA;
      case (FUNCT3[1:0])
         2'b00: begin
            w_be     = 4'b0001 << ADDR[1:0];
            w_wlanes = {4{WDATA[7:0]}};
         end
         2'b01: begin
            w_be     = ADDR[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{WDATA[15:0]}};
         end
         default: w_be = 4'b1111;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (w_store) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) mem[w_widx][8*i +: 8] <= w_wlanes[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      funct3_d = funct3_q;
      lane_d   = lane_q;
      word_d   = word_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (REQ) begin
               funct3_d = FUNCT3;
               lane_d   = ADDR[1:0];
               word_d   = w_rd_word;
               err_d    = w_bad;
               state_d  = RESP;
               if (w_bad) begin
                  rdata_d = '0;
               end else if (!WE) begin
                  if (RD_LAT <= 1) begin
                     rdata_d = f_extract(w_rd_word, FUNCT3, ADDR[1:0]);
                  end else begin
                     state_d = WAIT;
                     cnt_d   = c_wait_init;
                  end
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d = RESP;
               rdata_d = f_extract(word_q, funct3_q, lane_q);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         funct3_q <= '0;
         lane_q   <= '0;
         word_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         funct3_q <= funct3_d;
         lane_q   <= lane_d;
         word_q   <= word_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign READY = (state_q == RESP);
   assign ERR   = (state_q == RESP) && err_q;
   assign BUSY  = (state_q != IDLE);
   assign RDATA = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_ctrl : randomized and directed checks of dmem_ctrl (RD_LAT 1, 3)  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_dmem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req   [2];
   logic        we    [2];
   logic [2:0]  f3    [2];
   logic [11:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        ready [2];
   logic        err   [2];
   logic        busy  [2];

   int checks = 0;
   int errors = 0;

   logic [7:0] mm [2][64];

   dmem_ctrl #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1)) u_dut0 (
      .CLK(clk), .RESET_N(rst_n), .REQ(req[0]), .WE(we[0]), .FUNCT3(f3[0]),
      .ADDR(addr[0]), .WDATA(wdata[0]), .RDATA(rdata[0]), .READY(ready[0]),
      .ERR(err[0]), .BUSY(busy[0]));

   dmem_ctrl #(.DATA_W(32), .ADDR_W(10), .RD_LAT(3)) u_dut1 (
      .CLK(clk), .RESET_N(rst_n), .REQ(req[1]), .WE(we[1]), .FUNCT3(f3[1]),
      .ADDR(addr[1]), .WDATA(wdata[1]), .RDATA(rdata[1]), .READY(ready[1]),
      .ERR(err[1]), .BUSY(busy[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One complete transaction; the latency count is bounded so a stuck DUT still returns.
   task automatic access(input int d, input logic w, input logic [2:0] f,
                         input logic [11:0] a, input logic [31:0] wd, input bit scr,
                         output logic [31:0] rd, output logic e, output int lat,
                         output bit busy_ok, output logic busy_after, output logic ready_after);
      @(negedge clk);
      req[d] = 1'b1; we[d] = w; f3[d] = f; addr[d] = a; wdata[d] = wd;
      @(posedge clk); #1;
      lat = 1;
      busy_ok = 1'b1;
      while (ready[d] !== 1'b1 && lat < 12) begin
         if (busy[d] !== 1'b1) busy_ok = 1'b0;
         if (scr) begin
            req[d] = 1'($urandom); we[d] = 1'($urandom); f3[d] = 3'($urandom);
            addr[d] = 12'($urandom); wdata[d] = $urandom;
         end
         @(posedge clk); #1;
         lat++;
      end
      if (busy[d] !== 1'b1) busy_ok = 1'b0;
      rd = rdata[d];
      e  = err[d];
      req[d] = 1'b0;
      @(posedge clk); #1;
      busy_after  = busy[d];
      ready_after = ready[d];
   endtask

   // Reference behaviour from the RV32I load/store rules over a byte array.
   task automatic mdl_op(input int d, input logic w, input logic [2:0] f, input logic [11:0] a,
                         input logic [31:0] wd, output logic e, output logic [31:0] rd,
                         output int lat);
      int size;
      bit legal;
      logic [31:0] v;
      int ai;
      ai = int'(a);
      size = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
      legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
      e = !legal || (ai % size != 0);
      rd = '0;
      lat = 1;
      if (!e) begin
         if (w) begin
            for (int i = 0; i < size; i++) mm[d][ai+i] = wd[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mm[d][ai+i];
            if (!f[2] && size < 4 && v[8*size-1])
               for (int k = 8*size; k < 32; k++) v[k] = 1'b1;
            rd = v;
            lat = (d == 1) ? 3 : 1;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; f3[d] = '0; addr[d] = '0; wdata[d] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ready[d] !== 1'b0 || err[d] !== 1'b0 || busy[d] !== 1'b0 || rdata[d] !== 32'h0) begin
            errors++;
            $display("FAIL reset_state dut%0d: ready=%b err=%b busy=%b rdata=%h, want all 0",
                     d, ready[d], err[d], busy[d], rdata[d]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_word;
      logic [31:0] rd; logic e, ba, ra; int lat; bit bok;
      access(0, 1'b1, 3'b010, 12'h010, 32'h8765_4321, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (e !== 1'b0 || lat != 1) begin
         errors++; $display("FAIL sw_word: err=%b lat=%0d, want err=0 lat=1", e, lat);
      end
      access(0, 1'b0, 3'b010, 12'h010, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'h8765_4321 || e !== 1'b0 || lat != 1 || !bok || ba !== 1'b0) begin
         errors++;
         $display("FAIL lw_word: rdata=%h err=%b lat=%0d busy_ok=%0b busy_after=%b, want 87654321 0 1 1 0",
                  rd, e, lat, bok, ba);
      end
   endtask

   task automatic test_byte;
      logic [31:0] rd; logic e, ba, ra; int lat; bit bok;
      access(0, 1'b1, 3'b000, 12'h013, 32'h1234_56AB, 1'b0, rd, e, lat, bok, ba, ra);
      access(0, 1'b0, 3'b000, 12'h013, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'hFFFF_FFAB || e !== 1'b0) begin
         errors++; $display("FAIL lb: rdata=%h err=%b, want ffffffab 0", rd, e);
      end
      access(0, 1'b0, 3'b100, 12'h013, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'h0000_00AB || e !== 1'b0) begin
         errors++; $display("FAIL lbu: rdata=%h err=%b, want 000000ab 0", rd, e);
      end
      access(0, 1'b0, 3'b010, 12'h010, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'hAB65_4321) begin
         errors++; $display("FAIL lw_after_sb: rdata=%h, want ab654321", rd);
      end
   endtask

   task automatic test_half;
      logic [31:0] rd; logic e, ba, ra; int lat; bit bok;
      access(0, 1'b1, 3'b010, 12'h020, 32'h1111_2222, 1'b0, rd, e, lat, bok, ba, ra);
      access(0, 1'b1, 3'b001, 12'h022, 32'hDEAD_8001, 1'b0, rd, e, lat, bok, ba, ra);
      access(0, 1'b0, 3'b001, 12'h022, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'hFFFF_8001 || e !== 1'b0) begin
         errors++; $display("FAIL lh: rdata=%h err=%b, want ffff8001 0", rd, e);
      end
      access(0, 1'b0, 3'b101, 12'h022, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'h0000_8001) begin
         errors++; $display("FAIL lhu: rdata=%h, want 00008001", rd);
      end
      access(0, 1'b0, 3'b001, 12'h021, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'h0 || e !== 1'b1 || lat != 1) begin
         errors++; $display("FAIL lh_misaligned: rdata=%h err=%b lat=%0d, want 0 1 1", rd, e, lat);
      end
      access(0, 1'b0, 3'b010, 12'h020, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'h8001_2222) begin
         errors++; $display("FAIL lw_after_sh: rdata=%h, want 80012222", rd);
      end
   endtask

   task automatic test_illegal;
      logic [31:0] rd; logic e, ba, ra; int lat; bit bok;
      access(0, 1'b1, 3'b010, 12'h000, 32'h5A5A_5A5A, 1'b0, rd, e, lat, bok, ba, ra);
      access(0, 1'b1, 3'b011, 12'h000, 32'hFFFF_FFFF, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (e !== 1'b1 || lat != 1) begin
         errors++; $display("FAIL store_f3_011: err=%b lat=%0d, want 1 1", e, lat);
      end
      access(0, 1'b1, 3'b001, 12'h001, 32'hFFFF_FFFF, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (e !== 1'b1) begin
         errors++; $display("FAIL sh_misaligned: err=%b, want 1", e);
      end
      access(0, 1'b0, 3'b110, 12'h000, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (e !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL load_f3_110: err=%b rdata=%h, want 1 0", e, rd);
      end
      access(0, 1'b0, 3'b010, 12'h002, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (e !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL lw_misaligned: err=%b rdata=%h, want 1 0", e, rd);
      end
      access(0, 1'b0, 3'b010, 12'h000, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'h5A5A_5A5A || e !== 1'b0) begin
         errors++; $display("FAIL lw_after_bad_store: rdata=%h err=%b, want 5a5a5a5a 0", rd, e);
      end
   endtask

   task automatic test_latency3;
      logic [31:0] rd; logic e, ba, ra; int lat; bit bok;
      access(1, 1'b1, 3'b010, 12'h030, 32'hCAFE_F00D, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (e !== 1'b0 || lat != 1) begin
         errors++; $display("FAIL lat3_store: err=%b lat=%0d, want 0 1", e, lat);
      end
      access(1, 1'b0, 3'b010, 12'h030, 32'h0, 1'b1, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'hCAFE_F00D || e !== 1'b0 || lat != 3 || !bok || ba !== 1'b0 || ra !== 1'b0) begin
         errors++;
         $display("FAIL lat3_lw: rdata=%h err=%b lat=%0d busy_ok=%0b busy_after=%b ready_after=%b, want cafef00d 0 3 1 0 0",
                  rd, e, lat, bok, ba, ra);
      end
      access(1, 1'b0, 3'b001, 12'h032, 32'h0, 1'b1, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'hFFFF_CAFE || lat != 3) begin
         errors++; $display("FAIL lat3_lh: rdata=%h lat=%0d, want ffffcafe 3", rd, lat);
      end
      access(1, 1'b0, 3'b100, 12'h031, 32'h0, 1'b1, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'h0000_00F0 || lat != 3) begin
         errors++; $display("FAIL lat3_lbu: rdata=%h lat=%0d, want 000000f0 3", rd, lat);
      end
   endtask

   task automatic test_back_to_back;
      int pulses;
      pulses = 0;
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b0; f3[0] = 3'b010; addr[0] = 12'h010; wdata[0] = '0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ready[0] === 1'b1) begin
            pulses++;
            checks++;
            if (rdata[0] !== 32'hAB65_4321) begin
               errors++; $display("FAIL b2b_data: rdata=%h, want ab654321", rdata[0]);
            end
         end
      end
      req[0] = 1'b0;
      checks++;
      if (pulses != 3) begin
         errors++; $display("FAIL b2b_pulses: got %0d READY pulses in 6 cycles, want 3", pulses);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort;
      logic [31:0] rd; logic e, ba, ra; int lat; bit bok;
      int stray;
      access(1, 1'b1, 3'b010, 12'h008, 32'h1357_9BDF, 1'b0, rd, e, lat, bok, ba, ra);
      access(1, 1'b0, 3'b010, 12'h008, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'h1357_9BDF) begin
         errors++; $display("FAIL abort_pre_lw: rdata=%h, want 13579bdf", rd);
      end
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0; f3[1] = 3'b010; addr[1] = 12'h030;
      @(posedge clk); #1;
      req[1] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ready[1] !== 1'b0 || busy[1] !== 1'b0 || err[1] !== 1'b0 || rdata[1] !== 32'h0) begin
         errors++;
         $display("FAIL abort_reset_outputs: ready=%b busy=%b err=%b rdata=%h, want all 0",
                  ready[1], busy[1], err[1], rdata[1]);
      end
      stray = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (ready[1] !== 1'b0) stray++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (ready[1] !== 1'b0 || busy[1] !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++; $display("FAIL abort_no_ready: %0d stray READY/BUSY samples, want 0", stray);
      end
      access(1, 1'b0, 3'b010, 12'h008, 32'h0, 1'b0, rd, e, lat, bok, ba, ra);
      checks++;
      if (rd !== 32'h1357_9BDF || e !== 1'b0 || lat != 3) begin
         errors++; $display("FAIL abort_post_lw: rdata=%h err=%b lat=%0d, want 13579bdf 0 3", rd, e, lat);
      end
   endtask

   task automatic test_random;
      logic [31:0] rd, exp_rd, wd; logic e, exp_e, ba, ra, w; int lat, exp_lat, d; bit bok;
      logic [2:0] f; logic [11:0] a;
      for (int wi = 0; wi < 16; wi++) begin
         for (int dd = 0; dd < 2; dd++) begin
            wd = $urandom;
            mdl_op(dd, 1'b1, 3'b010, 12'(wi*4), wd, exp_e, exp_rd, exp_lat);
            access(dd, 1'b1, 3'b010, 12'(wi*4), wd, 1'b0, rd, e, lat, bok, ba, ra);
         end
      end
      for (int n = 0; n < 160; n++) begin
         d  = int'($urandom_range(0, 1));
         w  = 1'($urandom);
         f  = 3'($urandom);
         a  = 12'($urandom_range(0, 63));
         wd = $urandom;
         mdl_op(d, w, f, a, wd, exp_e, exp_rd, exp_lat);
         access(d, w, f, a, wd, 1'b1, rd, e, lat, bok, ba, ra);
         checks++;
         if (e !== exp_e || lat != exp_lat || !bok || ba !== 1'b0 ||
             ((exp_e || !w) && rd !== exp_rd)) begin
            errors++;
            $display("FAIL rand[%0d] dut%0d we=%b f3=%0d addr=%h: rdata=%h err=%b lat=%0d busy_ok=%0b busy_after=%b, want rdata=%h err=%b lat=%0d",
                     n, d, w, f, a, rd, e, lat, bok, ba, exp_rd, exp_e, exp_lat);
         end
      end
   endtask

   initial begin
      test_reset;
      test_word;
      test_byte;
      test_half;
      test_illegal;
      test_latency3;
      test_back_to_back;
      test_reset_abort;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
